// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause, EPC and PRId, plus exception/interrupt entry and eret.
// Define CP0_BADVADDR_EN to add BadVAddr (reg 8) and the badvaddr input.
module cp0 #(
   parameter logic [31:0] PRID = 32'h0000_2017
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [31:0] din,
   input  logic        we,
   input  logic [31:0] pc,
   input  logic        bd,
   input  logic [4:0]  exccode,
   input  logic        exl_clr,
   input  logic [5:0]  hwint,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0] badvaddr,
`endif
   output logic        intreq,
   output logic [31:0] epc,
   output logic [31:0] dout
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   logic [5:0]  im_reg;
   logic        exl_reg;
   logic        ie_reg;
   logic        bd_reg;
   logic [5:0]  ip_reg;
   logic [4:0]  exccode_reg;
   logic [31:0] epc_reg;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_reg;
`endif

   logic [5:0]  masked_int;
   logic        irq;
   logic        exc;
   logic [31:0] pc_word;
   logic [31:0] epc_next;
   logic [31:0] sr_word;
   logic [31:0] cause_word;
   logic [1:0]  unused_pc;

   for (genvar gi = 0; gi < 6; gi++) begin : g_mask
      assign masked_int[gi] = hwint[gi] & im_reg[gi];
   end

   assign irq    = (|masked_int) & ie_reg & ~exl_reg;
   assign exc    = (exccode != 5'd0) & ~exl_reg;
   assign intreq = irq | exc;

   // A delay-slot victim must restart at its branch so the branch is re-executed.
   assign pc_word   = {pc[31:2], 2'b00};
   assign epc_next  = bd ? (pc_word - 32'd4) : pc_word;
   assign unused_pc = pc[1:0];

   assign sr_word    = {16'h0000, im_reg, 8'h00, exl_reg, ie_reg};
   assign cause_word = {bd_reg, 15'h0000, ip_reg, 3'b000, exccode_reg, 2'b00};
   assign epc        = epc_reg;

   always_comb begin
      dout = 32'h0000_0000;
      case (a1)
         REG_SR:       dout = sr_word;
         REG_CAUSE:    dout = cause_word;
         REG_EPC:      dout = epc_reg;
         REG_PRID:     dout = PRID;
`ifdef CP0_BADVADDR_EN
         REG_BADVADDR: dout = badvaddr_reg;
`endif
         default:      dout = 32'h0000_0000;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         im_reg       <= 6'd0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ip_reg       <= 6'd0;
         exccode_reg  <= 5'd0;
         epc_reg      <= 32'd0;
`ifdef CP0_BADVADDR_EN
         badvaddr_reg <= 32'd0;
`endif
      end else begin
         ip_reg <= hwint;
         if (intreq) begin
            // Entry suppresses any eret or mtc0 in the same cycle.
            exl_reg     <= 1'b1;
            exccode_reg <= irq ? 5'd0 : exccode;
            bd_reg      <= bd;
            epc_reg     <= epc_next;
`ifdef CP0_BADVADDR_EN
            if (!irq && (exccode == 5'd4 || exccode == 5'd5))
               badvaddr_reg <= badvaddr;
`endif
         end else begin
            if (we && a2 == REG_SR) begin
               im_reg  <= din[15:10];
               exl_reg <= din[1];
               ie_reg  <= din[0];
            end
            if (we && a2 == REG_EPC)
               epc_reg <= {din[31:2], 2'b00};
            // Placed after the SR write so eret owns EXL when both happen.
            if (exl_clr)
               exl_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: register reads go through a scoreboard queue,
// drained by reading each expected register back through a1/dout.
module tb_cp0;

   localparam logic [31:0] PRID = 32'h0000_2017;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  a1 = 5'd0;
   logic [4:0]  a2 = 5'd0;
   logic [31:0] din = 32'd0;
   logic        we = 1'b0;
   logic [31:0] pc = 32'd0;
   logic        bd = 1'b0;
   logic [4:0]  exccode = 5'd0;
   logic        exl_clr = 1'b0;
   logic [5:0]  hwint = 6'd0;
   logic        intreq;
   logic [31:0] epc;
   logic [31:0] dout;
`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr = 32'd0;
`endif

   cp0 #(.PRID(PRID)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .a1       (a1),
      .a2       (a2),
      .din      (din),
      .we       (we),
      .pc       (pc),
      .bd       (bd),
      .exccode  (exccode),
      .exl_clr  (exl_clr),
      .hwint    (hwint),
`ifdef CP0_BADVADDR_EN
      .badvaddr (badvaddr),
`endif
      .intreq   (intreq),
      .epc      (epc),
      .dout     (dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [4:0]  r;
      logic [31:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic push_exp(input string tag, input logic [4:0] r, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.r   = r;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we      = 1'b0;
      exccode = 5'd0;
      exl_clr = 1'b0;
      bd      = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      push_exp("rst_sr", 5'd12, 32'h0);
      push_exp("rst_cause", 5'd13, 32'h0);
      push_exp("rst_epc", 5'd14, 32'h0);
      push_exp("rst_prid", 5'd15, PRID);
      push_exp("rst_reg9", 5'd9, 32'h0);
      push_exp("rst_reg8", 5'd8, 32'h0);
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
      n_checks++;
      if (epc !== 32'h0) begin n_fail++; $display("FAIL rst_epc_port: epc=%h required 0", epc); end
      exccode = 5'd3; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL rst_intreq_exc: intreq=%b required 1", intreq); end
      exccode = 5'd0; #1;
      n_checks++;
      if (intreq !== 1'b0) begin n_fail++; $display("FAIL rst_intreq_none: intreq=%b required 0", intreq); end
      @(negedge clk);
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_mtc0();
      exp_t e;
      we = 1'b1; a2 = 5'd12; din = 32'hFFFF_FFFF; step();
      a2 = 5'd13; step();
      a2 = 5'd14; din = 32'h1234_567B; #1;
      n_checks++;
      if (epc !== 32'h0) begin n_fail++; $display("FAIL mtc0_epc_pre: epc=%h required 0", epc); end
      step();
      we = 1'b0;
      n_checks++;
      if (epc !== 32'h1234_5678) begin n_fail++; $display("FAIL mtc0_epc_post: epc=%h required 12345678", epc); end
      push_exp("mtc0_sr", 5'd12, 32'h0000_FC03);
      push_exp("mtc0_cause_ro", 5'd13, 32'h0);
      push_exp("mtc0_epc", 5'd14, 32'h1234_5678);
      push_exp("mtc0_reg8", 5'd8, 32'h0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
      we = 1'b1; a2 = 5'd12; din = 32'h0; step();
      we = 1'b0;
   endtask

   task automatic test_irq();
      exp_t e;
      we = 1'b1; a2 = 5'd12; din = 32'h0000_0401; step();
      we = 1'b0;
      hwint = 6'b000001; pc = 32'h0000_3010; bd = 1'b0; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL irq_req: intreq=%b required 1", intreq); end
      step();
      n_checks++;
      if (intreq !== 1'b0) begin n_fail++; $display("FAIL irq_req_after: intreq=%b required 0", intreq); end
      n_checks++;
      if (epc !== 32'h0000_3010) begin n_fail++; $display("FAIL irq_epc_port: epc=%h required 00003010", epc); end
      push_exp("irq_cause", 5'd13, 32'h0000_0400);
      push_exp("irq_sr", 5'd12, 32'h0000_0403);
      push_exp("irq_epc", 5'd14, 32'h0000_3010);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
      hwint = 6'd0; exl_clr = 1'b1; step();
      idle();
      push_exp("irq_eret_sr", 5'd12, 32'h0000_0401);
      push_exp("irq_eret_cause", 5'd13, 32'h0000_0000);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
   endtask

   task automatic test_delay_slot();
      exp_t e;
      exccode = 5'd12; pc = 32'h0000_3024; bd = 1'b1; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL ds_req: intreq=%b required 1", intreq); end
      step();
      idle();
      push_exp("ds_epc", 5'd14, 32'h0000_3020);
      push_exp("ds_cause", 5'd13, 32'h8000_0030);
      push_exp("ds_sr", 5'd12, 32'h0000_0403);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
      exl_clr = 1'b1; step();
      idle();
   endtask

   task automatic test_irq_exc();
      exp_t e;
      we = 1'b1; a2 = 5'd12; din = 32'h0000_FC01; step();
      we = 1'b0;
      hwint = 6'b100000; exccode = 5'd10; pc = 32'h0000_4000; bd = 1'b0; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL ie_req: intreq=%b required 1", intreq); end
      step();
      idle();
      push_exp("ie_cause", 5'd13, 32'h0000_8000);
      push_exp("ie_epc", 5'd14, 32'h0000_4000);
      push_exp("ie_sr", 5'd12, 32'h0000_FC03);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      // hwint[5] still high: eret reopens the pending interrupt next cycle.
      exl_clr = 1'b1; step();
      exl_clr = 1'b0;
      we = 1'b1; a2 = 5'd14; din = 32'h1234_5678; pc = 32'h0000_5008; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL b2b_req: intreq=%b required 1", intreq); end
      step();
      we = 1'b0;
      n_checks++;
      if (epc !== 32'h0000_5008) begin n_fail++; $display("FAIL b2b_epc_capture: epc=%h required 00005008", epc); end
      hwint = 6'd0; exl_clr = 1'b1; we = 1'b1; a2 = 5'd12; din = 32'h0000_FC03; step();
      idle();
      n_checks++;
      if (intreq !== 1'b0) begin n_fail++; $display("FAIL b2b_req_after: intreq=%b required 0", intreq); end
      n_checks++;
      if (epc !== 32'h0000_5008) begin n_fail++; $display("FAIL b2b_epc_eret: epc=%h required 00005008", epc); end
      push_exp("b2b_sr", 5'd12, 32'h0000_FC01);
      push_exp("b2b_epc", 5'd14, 32'h0000_5008);
      push_exp("b2b_cause", 5'd13, 32'h0000_0000);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
   endtask

   task automatic test_exl_mask();
      exp_t e;
      exccode = 5'd7; pc = 32'h0000_6001; bd = 1'b0; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL mask_req: intreq=%b required 1", intreq); end
      step();
      exccode = 5'd9; pc = 32'h0000_6100; #1;
      n_checks++;
      if (intreq !== 1'b0) begin n_fail++; $display("FAIL mask_blocked: intreq=%b required 0", intreq); end
      step();
      idle();
      push_exp("mask_cause", 5'd13, 32'h0000_001C);
      push_exp("mask_epc", 5'd14, 32'h0000_6000);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
      exl_clr = 1'b1; step();
      idle();
   endtask

   task automatic test_async_reset();
      exp_t e;
      hwint = 6'b000001; pc = 32'h0000_7000; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL ar_req: intreq=%b required 1", intreq); end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (epc !== 32'h0) begin n_fail++; $display("FAIL ar_epc_port: epc=%h required 0", epc); end
      n_checks++;
      if (intreq !== 1'b0) begin n_fail++; $display("FAIL ar_req_off: intreq=%b required 0", intreq); end
      push_exp("ar_sr", 5'd12, 32'h0);
      push_exp("ar_cause", 5'd13, 32'h0);
      push_exp("ar_epc", 5'd14, 32'h0);
      push_exp("ar_prid", 5'd15, PRID);
      push_exp("ar_reg9", 5'd9, 32'h0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
      step();
      step();
      n_checks++;
      if (epc !== 32'h0) begin n_fail++; $display("FAIL ar_epc_held: epc=%h required 0", epc); end
      exccode = 5'd2; #1;
      n_checks++;
      if (intreq !== 1'b1) begin n_fail++; $display("FAIL ar_req_exc: intreq=%b required 1", intreq); end
      exccode = 5'd0; hwint = 6'd0;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      push_exp("ar_post_sr", 5'd12, 32'h0);
      push_exp("ar_post_cause", 5'd13, 32'h0);
      while (sb.size() != 0) begin
         e = sb.pop_front(); a1 = e.r; #1;
         n_checks++;
         if (dout !== e.v) begin n_fail++; $display("FAIL %s: dout=%h required %h", e.tag, dout, e.v); end
      end
   endtask

   initial begin
      test_reset();
      test_mtc0();
      test_irq();
      test_delay_slot();
      test_irq_exc();
      test_back_to_back();
      test_exl_mask();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have parameter PRID, default 32'h0000_2017, the constant value returned for reads of register 15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port a1, input, 5, the mfc0 read register number.
REQ-005 SHALL have port a2, input, 5, the mtc0 write register number.
REQ-006 SHALL have port din, input, 32, the mtc0 write data.
REQ-007 SHALL have port we, input, 1, the mtc0 write enable.
REQ-008 SHALL have port pc, input, 32, the PC of the M-stage (victim) instruction.
REQ-009 SHALL have port bd, input, 1, set when the victim instruction is in a branch delay slot.
REQ-010 SHALL have port exccode, input, 5, the victim's exception code; 0 means none.
REQ-011 SHALL have port exl_clr, input, 1, eret retiring in M.
REQ-012 SHALL have port hwint, input, 6, the external interrupt lines.
REQ-013 SHALL have port intreq, output, 1, request to flush the pipeline and redirect to the handler.
REQ-014 SHALL have port epc, output, 32, the current EPC register, consumed by next-PC logic for eret.
REQ-015 SHALL have port dout, output, 32, the mfc0 read data.

Function
REQ-016 SHALL implement SR(12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
REQ-017 SHALL implement Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0. Cause is writable only by hardware; mtc0 to 13 is ignored.
REQ-018 SHALL implement EPC(14) as a full 32-bit register and PRId(15) as the read-only value PRID.
REQ-019 SHALL compute intreq combinationally: irq = |(hwint & IM) & IE & !EXL; exc = (exccode != 0) & !EXL; intreq = irq | exc.
REQ-020 SHALL, at each edge where intreq=1, perform all of the following:
- set EXL=1;
- set ExcCode = irq ? 0 : exccode (an interrupt outranks a synchronous exception);
- set BD=bd;
- set EPC = bd ? {pc[31:2],2'b00}-4 : {pc[31:2],2'b00}.
REQ-021 SHALL sample IP <= hwint on every edge, regardless of other activity.
REQ-022 SHALL clear EXL at an edge where exl_clr=1 and intreq=0.
REQ-023 SHALL apply an mtc0 write (we=1, a2 in {12,14}) only when intreq=0. EPC writes are word-aligned with din[1:0] forced to 0.
REQ-024 SHALL give simultaneous events this priority: exception entry > eret > mtc0. An eret together with an mtc0 to SR applies both, and EXL takes the eret value.
REQ-025 SHALL drive dout combinationally from a1 and the current register state, with no write forwarding; unimplemented register numbers read 32'h0.
REQ-026 SHALL drive epc directly from the EPC register, so it shows the pre-edge value in the cycle an mtc0 writes EPC.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously clear SR, Cause and EPC to 0 (and BadVAddr when compiled in). Consequently epc=0, dout=0 (or PRID when a1=15), and intreq=(exccode!=0).
REQ-028 SHALL, when reset is asserted mid-entry, win over the pending capture; no partial update remains.

Configuration
REQ-029 SHALL, with CP0_BADVADDR_EN defined, implement BadVAddr(8) and an extra input badvaddr (32 bits). On exception entry with exccode 4 (AdEL) or 5 (AdES), BadVAddr <= badvaddr; the register is read-only and resets to 0.
REQ-030 SHALL, without CP0_BADVADDR_EN, omit the badvaddr port and the register, and reads of register 8 return 0.

Verification
REQ-031 Interrupt enable then fire:
- mtc0 SR=32'h0000_0401, then hwint=6'b000001 with pc=32'h0000_3010, bd=0;
- -> intreq=1 the same cycle; next cycle EPC=32'h0000_3010, Cause=32'h0000_0400, EXL=1, intreq=0.
REQ-032 Delay-slot exception: exccode=12, pc=32'h0000_3024, bd=1, EXL=0 -> EPC=32'h0000_3020, Cause=32'h8000_0030.
REQ-033 Interrupt plus exception: IM=all, IE=1, hwint=6'b100000 and exccode=10 in the same cycle -> ExcCode=0, Cause[15]=1.
REQ-034 Simultaneous events and eret:
- intreq=1 together with we=1, a2=14, din=32'h1234_5678 -> EPC holds the captured pc, not din.
- a following exl_clr=1 -> EXL=0, and epc matches the captured value.
REQ-035 Async reset: drop reset_n mid-cycle during an active interrupt -> SR, Cause and EPC read 0 immediately; dout with a1=15 returns PRID; a1=9 returns 0.
REQ-036 With CP0_BADVADDR_EN: exccode=4, badvaddr=32'h0000_0003 -> reg 8 reads 32'h0000_0003. Without the macro, reg 8 reads 0.
